lsu_bus_bridge: RTL and testbench
=================================

Name: lsu_bus_bridge

Overview:
- Parametrised load/store unit between the MEM stage and a variable-latency data bus with a valid/ready request channel and an rvalid response channel.
- Replaces the fixed single-cycle DMEM interface (RD/WR/byte_mark).
- Generates the pipeline stall.
- Aligns store data and byte masks, sign/zero-extends loads, and flags misaligned accesses and bus timeouts.

Parameters:
- DATA_WIDTH, 32, bus and register data width; legal values 32 or 64.
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT_CYCLES, 256, maximum number of cycles spent in REQ+WAIT_RSP before abort; 0 disables the timeout.
- LANES, DATA_WIDTH/8, derived localparam: number of byte lanes.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- req_rd_i  in  1  MEM-stage load request; held stable while stall_o=1.
- req_wr_i  in  1  MEM-stage store request; held stable while stall_o=1.
- req_add_i  in  ADDR_WIDTH  byte address.
- req_wdata_i  in  DATA_WIDTH  store data, right-aligned.
- req_funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 011 D (only when DATA_WIDTH=64), 100 BU, 101 HU, 110 WU (only when DATA_WIDTH=64).
- stall_o  out  1  freeze IF/ID/EX/MEM pipeline registers.
- rdata_o  out  DATA_WIDTH  formatted load data.
- rdata_valid_o  out  1  rdata_o valid this cycle.
- err_misalign_o  out  1  one-cycle pulse: misaligned or illegal access.
- err_timeout_o  out  1  one-cycle pulse: bus timeout.
- bus_valid_o  out  1  request valid.
- bus_ready_i  in  1  request accepted.
- bus_we_o  out  1  1 = write.
- bus_add_o  out  ADDR_WIDTH  address, lane bits forced to 0.
- bus_wdata_o  out  DATA_WIDTH  lane-replicated store data.
- bus_byte_mark_o  out  LANES  active byte lanes.
- bus_rvalid_i  in  1  read response valid.
- bus_rdata_i  in  DATA_WIDTH  read response data.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values (all outputs 0):
  - state=IDLE, timeout counter=0, all latched request fields=0.
  - stall_o, rdata_o, rdata_valid_o, err_* , bus_valid_o, bus_we_o, bus_add_o, bus_wdata_o, bus_byte_mark_o all 0.
- Reset mid-operation: on rst_n low, bus_valid_o drops immediately (asynchronous). Any in-flight transaction is abandoned. A late bus_rvalid_i arriving after reset is ignored.
- Alignment: lane offset off = req_add_i[log2(LANES)-1:0].
  - H requires off[0]=0; W requires off[1:0]=0; D requires off=0.
  - D/WU funct3 with DATA_WIDTH=32, and funct3 111, are illegal.
- Simultaneous req_rd_i and req_wr_i: treated as a store.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE:
  - Request legal/aligned: latch address, funct3, data and we; go to REQ. stall_o=1 combinationally in this same cycle.
  - Request misaligned/illegal: err_misalign_o=1 for one cycle, no bus activity, stall_o=0, stay in IDLE.
- REQ:
  - bus_valid_o=1 with stable address, we, wdata and mask until bus_ready_i=1.
  - On handshake: store goes to DONE; load goes to WAIT_RSP.
  - bus_rvalid_i in the same cycle as the load handshake counts as the response: go straight to DONE.
  - stall_o=1.
- WAIT_RSP:
  - On bus_rvalid_i: register the formatted data into rdata_o; go to DONE.
  - stall_o=1.
- DONE:
  - stall_o=0 (pipeline advances this cycle).
  - rdata_valid_o=1 for a load; rdata_o holds its value until the next load completes.
  - Always returns to IDLE. A request present during DONE is never re-accepted.
- Timeout:
  - Counter increments each cycle in REQ or WAIT_RSP and clears in IDLE.
  - When it reaches TIMEOUT_CYCLES: go to DONE, bus_valid_o=0, err_timeout_o=1 for one cycle, rdata_o=0, rdata_valid_o=0.
- Minimum latency: store with ready in the first REQ cycle = 3 cycles of request (IDLE->REQ->DONE), 2 of them stalled. Load with zero-wait response = 3 cycles.
- Store formatting:
  - bus_wdata_o = size slice replicated across all lanes.
  - bus_byte_mark_o = (B:1, H:3, W:4'hF, D:8'hFF) << off.
- Load formatting: select the bytes at off, then sign-extend (B/H/W) or zero-extend (BU/HU/WU) to DATA_WIDTH.

Decomposition:
- Shared package/include (defi.vh): funct3 size encodings, FSM state encodings, LANES/offset-width helper.
- One sub-module, lsu_data_align: combinational store replicate/mask and load extract/extend. Reused by a future I-cache fill path.

Test Plan:
- SW 0x1000 data 0x11223344, bus_ready_i at cycle 1 -> bus_byte_mark_o=4'hF, bus_add_o=0x1000, stall_o high 2 cycles, no rdata_valid_o.
- SB 0x1003 data 0xAB -> bus_wdata_o=0xABABABAB, mask=4'b1000.
- LB 0x1002, bus_rdata_i=0x00800000 after 3 wait cycles -> rdata_o=0xFFFFFF80 with rdata_valid_o in DONE. Repeat as LBU -> rdata_o=0x00000080. stall_o high exactly from request until DONE.
- LW 0x1002 -> err_misalign_o pulse, bus_valid_o stays 0, stall_o=0. D access with DATA_WIDTH=32 -> same response.
- TIMEOUT_CYCLES=4, bus_ready_i held 0 -> after 4 cycles err_timeout_o pulse, bus_valid_o=0, stall releases, rdata_o=0.
- rst_n pulsed low while in WAIT_RSP -> all outputs 0 immediately; bus_rvalid_i asserted after reset releases causes no rdata_valid_o.

Source files
------------

// File: rtl/lsu_bus_bridge_pkg.sv
// rtl/lsu_bus_bridge_pkg.sv - shared encodings and helpers for the LSU bus bridge
package lsu_bus_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  function automatic int lane_off_w(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // off is the lane offset zero-padded to 3 bits; wide means a 64-bit bus
  function automatic logic access_legal(input logic [2:0] funct3, input logic [2:0] off,
                                        input logic wide);
    logic ok;
    case (funct3)
      F3_B, F3_BU: ok = 1'b1;
      F3_H, F3_HU: ok = (off[0] == 1'b0);
      F3_W:        ok = (off[1:0] == 2'b00);
      F3_D:        ok = wide && (off == 3'b000);
      F3_WU:       ok = wide && (off[1:0] == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - store lane replication/masking and load extraction/extension
module lsu_data_align
  import lsu_bus_bridge_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int LANES      = DATA_WIDTH / 8,
  localparam int OFF_W      = $clog2(DATA_WIDTH / 8)
) (
  input  logic [2:0]            i_funct3,
  input  logic [OFF_W-1:0]      i_off,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [LANES-1:0]      o_mask,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] w_shift;

  always_comb begin
    o_wdata = '0;
    o_mask  = '0;
    case (i_funct3[1:0])
      2'b00: begin
        o_wdata = {LANES{i_wdata[7:0]}};
        o_mask  = LANES'(1) << i_off;
      end
      2'b01: begin
        o_wdata = {(LANES / 2){i_wdata[15:0]}};
        o_mask  = LANES'(3) << i_off;
      end
      2'b10: begin
        o_wdata = {(LANES / 4){i_wdata[31:0]}};
        o_mask  = LANES'(15) << i_off;
      end
      default: begin
        o_wdata = i_wdata;
        o_mask  = '1;
      end
    endcase
  end

  assign w_shift = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_rdata = '0;
    case (i_funct3)
      F3_B: begin
        o_rdata      = {DATA_WIDTH{w_shift[7]}};
        o_rdata[7:0] = w_shift[7:0];
      end
      F3_BU: o_rdata[7:0] = w_shift[7:0];
      F3_H: begin
        o_rdata       = {DATA_WIDTH{w_shift[15]}};
        o_rdata[15:0] = w_shift[15:0];
      end
      F3_HU: o_rdata[15:0] = w_shift[15:0];
      F3_W: begin
        o_rdata       = {DATA_WIDTH{w_shift[31]}};
        o_rdata[31:0] = w_shift[31:0];
      end
      F3_WU: o_rdata[31:0] = w_shift[31:0];
      default: o_rdata = w_shift;
    endcase
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// rtl/lsu_bus_bridge.sv - MEM-stage load/store unit bridging to a variable-latency data bus
module lsu_bus_bridge
  import lsu_bus_bridge_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int ADDR_WIDTH     = 32,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int LANES          = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_rd_i,
  input  logic                  req_wr_i,
  input  logic [ADDR_WIDTH-1:0] req_add_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [2:0]            req_funct3_i,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rdata_valid_o,
  output logic                  err_misalign_o,
  output logic                  err_timeout_o,
  output logic                  bus_valid_o,
  input  logic                  bus_ready_i,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_add_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  output logic [LANES-1:0]      bus_byte_mark_o,
  input  logic                  bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

  localparam int   OFF_W = lane_off_w(DATA_WIDTH);
  localparam logic WIDE  = (DATA_WIDTH == 64);
  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);
  // Holds up to TIMEOUT_CYCLES+1, reached when a load handshakes on the last REQ cycle
  localparam int   CNT_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_e            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_add;
  logic [2:0]            r_f3;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rdata_valid;
  logic                  r_err_timeout;

  logic                  w_req;
  logic                  w_legal;
  logic [2:0]            w_off3;
  logic                  w_bus_valid;
  logic                  w_to_hit;
  logic [DATA_WIDTH-1:0] w_st_data;
  logic [LANES-1:0]      w_st_mask;
  logic [DATA_WIDTH-1:0] w_ld_data;

  // rst_n gating keeps the combinational outputs quiet while reset is held
  assign w_req    = rst_n && (req_rd_i || req_wr_i) && (r_state == ST_IDLE);
  assign w_off3   = 3'(req_add_i[OFF_W-1:0]);
  assign w_legal  = access_legal(req_funct3_i, w_off3, WIDE);
  assign w_to_hit = TO_EN && (r_cnt >= TO_LAST);

  lsu_data_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .i_funct3 (r_f3),
    .i_off    (r_add[OFF_W-1:0]),
    .i_wdata  (r_wdata),
    .i_rdata  (bus_rdata_i),
    .o_wdata  (w_st_data),
    .o_mask   (w_st_mask),
    .o_rdata  (w_ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_add         <= '0;
      r_f3          <= '0;
      r_wdata       <= '0;
      r_we          <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_rdata_valid <= 1'b0;
      r_err_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_req && w_legal) begin
            r_add   <= req_add_i;
            r_f3    <= req_funct3_i;
            r_wdata <= req_wdata_i;
            r_we    <= req_wr_i;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (bus_ready_i) begin
            if (r_we) begin
              r_state <= ST_DONE;
            end else if (bus_rvalid_i) begin
              r_rdata       <= w_ld_data;
              r_rdata_valid <= 1'b1;
              r_state       <= ST_DONE;
            end else begin
              r_state <= ST_WAIT_RSP;
            end
          end else if (w_to_hit) begin
            r_rdata       <= '0;
            r_err_timeout <= 1'b1;
            r_state       <= ST_DONE;
          end
        end
        ST_WAIT_RSP: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (bus_rvalid_i) begin
            r_rdata       <= w_ld_data;
            r_rdata_valid <= 1'b1;
            r_state       <= ST_DONE;
          end else if (w_to_hit) begin
            r_rdata       <= '0;
            r_err_timeout <= 1'b1;
            r_state       <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_bus_valid     = (r_state == ST_REQ);
  assign bus_valid_o     = w_bus_valid;
  assign bus_we_o        = w_bus_valid && r_we;
  assign bus_add_o       = w_bus_valid ? {r_add[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign bus_wdata_o     = w_bus_valid ? w_st_data : '0;
  assign bus_byte_mark_o = w_bus_valid ? w_st_mask : '0;

  assign stall_o        = (w_req && w_legal) || (r_state == ST_REQ) || (r_state == ST_WAIT_RSP);
  assign err_misalign_o = w_req && !w_legal;
  assign err_timeout_o  = r_err_timeout;
  assign rdata_o        = r_rdata;
  assign rdata_valid_o  = r_rdata_valid;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// tb/tb_lsu_bus_bridge.sv - scoreboard bench for lsu_bus_bridge
module tb_lsu_bus_bridge;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_rd_i = 1'b0;
  logic          req_wr_i = 1'b0;
  logic [AW-1:0] req_add_i = '0;
  logic [DW-1:0] req_wdata_i = '0;
  logic [2:0]    req_funct3_i = '0;
  logic          stall_o;
  logic [DW-1:0] rdata_o;
  logic          rdata_valid_o;
  logic          err_misalign_o;
  logic          err_timeout_o;
  logic          bus_valid_o;
  logic          bus_ready_i = 1'b0;
  logic          bus_we_o;
  logic [AW-1:0] bus_add_o;
  logic [DW-1:0] bus_wdata_o;
  logic [3:0]    bus_byte_mark_o;
  logic          bus_rvalid_i = 1'b0;
  logic [DW-1:0] bus_rdata_i = '0;

  always #5 clk = ~clk;

  lsu_bus_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_rd_i        (req_rd_i),
    .req_wr_i        (req_wr_i),
    .req_add_i       (req_add_i),
    .req_wdata_i     (req_wdata_i),
    .req_funct3_i    (req_funct3_i),
    .stall_o         (stall_o),
    .rdata_o         (rdata_o),
    .rdata_valid_o   (rdata_valid_o),
    .err_misalign_o  (err_misalign_o),
    .err_timeout_o   (err_timeout_o),
    .bus_valid_o     (bus_valid_o),
    .bus_ready_i     (bus_ready_i),
    .bus_we_o        (bus_we_o),
    .bus_add_o       (bus_add_o),
    .bus_wdata_o     (bus_wdata_o),
    .bus_byte_mark_o (bus_byte_mark_o),
    .bus_rvalid_i    (bus_rvalid_i),
    .bus_rdata_i     (bus_rdata_i)
  );

  typedef struct {
    logic [31:0] add;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } bus_t;

  bus_t        exp_bus[$];
  logic [31:0] exp_rd[$];
  int          exp_err[$];
  int          n_pass = 0;
  int          n_checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    $display("FAIL %s: event with empty expectation queue", name);
  endtask

  task automatic expect_bus(input logic [31:0] add, input logic we, input logic [31:0] wdata,
                            input logic [3:0] mask);
    bus_t e;
    e.add = add; e.we = we; e.wdata = wdata; e.mask = mask;
    exp_bus.push_back(e);
  endtask

  // Monitor: pops and compares whenever the DUT presents an event
  bus_t        mon_e;
  logic [31:0] mon_rd;
  int          mon_err;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus_valid_o && bus_ready_i) begin
          if (exp_bus.size() == 0) unexpected("bus_handshake");
          else begin
            mon_e = exp_bus.pop_front();
            check("bus_add", bus_add_o, mon_e.add);
            check("bus_we", bus_we_o, mon_e.we);
            check("bus_mask", bus_byte_mark_o, mon_e.mask);
            if (mon_e.we) check("bus_wdata", bus_wdata_o, mon_e.wdata);
          end
        end
        if (rdata_valid_o) begin
          if (exp_rd.size() == 0) unexpected("rdata_valid");
          else begin
            mon_rd = exp_rd.pop_front();
            check("rdata", rdata_o, mon_rd);
            check("rdata_stall_released", stall_o, 0);
          end
        end
        if (err_misalign_o) begin
          if (exp_err.size() == 0) unexpected("err_misalign");
          else begin
            mon_err = exp_err.pop_front();
            check("err_kind_misalign", mon_err, 1);
            check("misalign_no_bus", bus_valid_o, 0);
            check("misalign_no_stall", stall_o, 0);
          end
        end
        if (err_timeout_o) begin
          if (exp_err.size() == 0) unexpected("err_timeout");
          else begin
            mon_err = exp_err.pop_front();
            check("err_kind_timeout", mon_err, 2);
            check("timeout_rdata_zero", rdata_o, 0);
            check("timeout_bus_idle", bus_valid_o, 0);
            check("timeout_stall_released", stall_o, 0);
            check("timeout_no_rdata_valid", rdata_valid_o, 0);
          end
        end
      end
    end
  end

  // Drives one MEM-stage request plus a bus responder; called #1 after a posedge
  task automatic run_req(input string tag, input logic rd, input logic wr, input logic [31:0] add,
                         input logic [31:0] wdata, input logic [2:0] f3, input int rdy_dly,
                         input int rsp_dly, input logic [31:0] brdata, input int exp_stalls);
    int stalls = 0;
    int req_cnt = 0;
    int since = -1;
    bit done = 1'b0;
    req_rd_i = rd; req_wr_i = wr; req_add_i = add; req_wdata_i = wdata; req_funct3_i = f3;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      bus_ready_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
      if (since >= 0) since++;
      if (bus_valid_o) begin
        if (req_cnt == rdy_dly) begin
          bus_ready_i = 1'b1;
          since = 0;
        end
        req_cnt++;
      end
      if (!wr && since == rsp_dly) begin
        bus_rvalid_i = 1'b1;
        bus_rdata_i = brdata;
      end
      @(negedge clk);
      if (stall_o) stalls++;
      else done = 1'b1;
      @(posedge clk); #1;
    end
    check({tag, "_completed"}, done, 1);
    check({tag, "_stall_cycles"}, stalls, exp_stalls);
    req_rd_i = 1'b0; req_wr_i = 1'b0; req_add_i = '0; req_wdata_i = '0; req_funct3_i = '0;
    bus_ready_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {stall_o, rdata_valid_o, err_misalign_o, err_timeout_o,
                           bus_valid_o, bus_we_o, bus_byte_mark_o}, 0);
    check({tag, "_bus_add"}, bus_add_o, 0);
    check({tag, "_bus_wdata"}, bus_wdata_o, 0);
    check({tag, "_rdata"}, rdata_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  int late;
  initial begin
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    expect_bus(32'h1000, 1'b1, 32'h11223344, 4'hF);
    run_req("sw", 0, 1, 32'h1000, 32'h11223344, 3'b010, 0, 0, 0, 2);
    expect_bus(32'h1000, 1'b1, 32'hABABABAB, 4'b1000);
    run_req("sb", 0, 1, 32'h1003, 32'h123456AB, 3'b000, 0, 0, 0, 2);
    expect_bus(32'h1000, 1'b0, 32'h0, 4'b0100);
    exp_rd.push_back(32'hFFFFFF80);
    run_req("lb", 1, 0, 32'h1002, 32'h0, 3'b000, 0, 3, 32'h00800000, 5);
    expect_bus(32'h1000, 1'b0, 32'h0, 4'b0100);
    exp_rd.push_back(32'h00000080);
    run_req("lbu", 1, 0, 32'h1002, 32'h0, 3'b100, 0, 3, 32'h00800000, 5);
    expect_bus(32'h1000, 1'b1, 32'hBEEFBEEF, 4'b1100);
    run_req("sh", 0, 1, 32'h1002, 32'hCAFEBEEF, 3'b001, 1, 0, 0, 3);
    expect_bus(32'h1004, 1'b0, 32'h0, 4'b1100);
    exp_rd.push_back(32'hFFFF8001);
    run_req("lh", 1, 0, 32'h1006, 32'h0, 3'b001, 2, 0, 32'h80015555, 4);
    expect_bus(32'h1000, 1'b0, 32'h0, 4'b0011);
    exp_rd.push_back(32'h0000F00D);
    run_req("lhu", 1, 0, 32'h1000, 32'h0, 3'b101, 0, 1, 32'h1234F00D, 3);
    expect_bus(32'h2004, 1'b0, 32'h0, 4'hF);
    exp_rd.push_back(32'h89ABCDEF);
    run_req("lw", 1, 0, 32'h2004, 32'h0, 3'b010, 1, 1, 32'h89ABCDEF, 4);
    expect_bus(32'h3008, 1'b1, 32'h0BADF00D, 4'hF);
    run_req("rdwr_store", 1, 1, 32'h3008, 32'h0BADF00D, 3'b010, 0, 0, 0, 2);
    check("rdata_hold", rdata_o, 32'h89ABCDEF);

    exp_err.push_back(1);
    run_req("lw_mis", 1, 0, 32'h1002, 32'h0, 3'b010, 0, 0, 0, 0);
    exp_err.push_back(1);
    run_req("ld_dw32", 1, 0, 32'h1000, 32'h0, 3'b011, 0, 0, 0, 0);
    exp_err.push_back(1);
    run_req("f3_111", 1, 0, 32'h1000, 32'h0, 3'b111, 0, 0, 0, 0);
    exp_err.push_back(1);
    run_req("lwu_dw32", 1, 0, 32'h1000, 32'h0, 3'b110, 0, 0, 0, 0);
    exp_err.push_back(1);
    run_req("sh_mis", 0, 1, 32'h1001, 32'h1234, 3'b001, 0, 0, 0, 0);
    exp_err.push_back(1);
    run_req("lh_mis", 1, 0, 32'h1003, 32'h0, 3'b001, 0, 0, 0, 0);
    check("misalign_rdata_hold", rdata_o, 32'h89ABCDEF);

    exp_err.push_back(2);
    run_req("sw_timeout", 0, 1, 32'h4000, 32'h55AA55AA, 3'b010, 99, 0, 0, 5);
    expect_bus(32'h5000, 1'b0, 32'h0, 4'hF);
    exp_err.push_back(2);
    run_req("lw_timeout", 1, 0, 32'h5000, 32'h0, 3'b010, 0, 99, 32'hFFFFFFFF, 5);
    check("timeout_rdata_hold", rdata_o, 0);

    expect_bus(32'h1000, 1'b0, 32'h0, 4'b0010);
    exp_rd.push_back(32'h0000007F);
    run_req("lb_after_to", 1, 0, 32'h1001, 32'h0, 3'b000, 0, 0, 32'h00007F00, 2);

    expect_bus(32'h6000, 1'b0, 32'h0, 4'hF);
    req_rd_i = 1'b1; req_add_i = 32'h6000; req_funct3_i = 3'b010;
    @(posedge clk); #1;
    bus_ready_i = 1'b1;
    @(posedge clk); #1;
    bus_ready_i = 1'b0;
    check("wait_rsp_stall", stall_o, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    req_rd_i = 1'b0; req_add_i = '0; req_funct3_i = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF;
    late = 0;
    repeat (3) begin
      @(negedge clk);
      if (rdata_valid_o || stall_o) late++;
      @(posedge clk); #1;
      bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    end
    check("late_rvalid_ignored", late, 0);
    check("post_reset_rdata", rdata_o, 0);

    check("exp_bus_drained", exp_bus.size(), 0);
    check("exp_rd_drained", exp_rd.size(), 0);
    check("exp_err_drained", exp_err.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
